clk_div_sched: RTL

// Run-time programmable clock divider controller. It generates a divided clock (clk_o) and a
// one-cycle end-of-period strobe (tick) from clk.
// It replaces the fixed divide-by-4 path. The divide ratio changes only through a req/ack

---
 rtl/clk_div_sched.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/clk_div_sched.sv
// clk_div_sched: run-time programmable clock divider controller.
// Generates a registered divided clock (clk_o) and an end-of-period strobe (tick).
// Ratio changes go through a req/ack handshake and take effect only at a period
// boundary, so clk_o never shows a runt pulse.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   en       in   1 = run divider, 0 = idle (clk_o low)
//   div_req  in   ratio change request level, held until div_ack/div_err
//   div_val  in   requested ratio N (valid 2..2**CNT_W-1)
//   div_ack  out  one-cycle pulse: requested ratio applied
//   div_err  out  one-cycle pulse: request rejected (div_val < 2)
//   div_cur  out  ratio currently in effect
//   clk_o    out  divided clock, high for cnt < N>>1
//   tick     out  high in the cycle where cnt == N-1
//   busy     out  request pending, waiting for the period boundary
module clk_div_sched #(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             div_req,
    input  logic [CNT_W-1:0] div_val,
    output logic             div_ack,
    output logic             div_err,
    output logic [CNT_W-1:0] div_cur,
    output logic             clk_o,
    output logic             tick,
    output logic             busy
);

    localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_SW_PEND = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_cur;
    logic [CNT_W-1:0] r_pend;
    logic             r_clk_o;
    logic             r_tick;
    logic             r_busy;
    logic             r_div_ack;
    logic             r_div_err;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_pend_nxt;
    logic [CNT_W-1:0] w_hi_len;
    logic             w_clk_o_nxt;
    logic             w_tick_nxt;
    logic             w_busy_nxt;
    logic             w_ack_nxt;
    logic             w_err_nxt;
    logic             w_run_nxt;
    logic             w_accept;
    logic             w_valid;
    logic             w_wrap;

    // A request still visible during its own ack/err cycle must not be re-captured.
    assign w_accept = div_req && !r_div_ack && !r_div_err && (r_state != ST_SW_PEND);
    assign w_valid  = (div_val >= CNT_W'(2));
    assign w_wrap   = (r_cnt == (r_div_cur - CNT_W'(1)));

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_div_cur <= DEF_DIV;
            r_pend    <= DEF_DIV;
            r_clk_o   <= 1'b0;
            r_tick    <= 1'b0;
            r_busy    <= 1'b0;
            r_div_ack <= 1'b0;
            r_div_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_div_cur <= w_div_nxt;
            r_pend    <= w_pend_nxt;
            r_clk_o   <= w_clk_o_nxt;
            r_tick    <= w_tick_nxt;
            r_busy    <= w_busy_nxt;
            r_div_ack <= w_ack_nxt;
            r_div_err <= w_err_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!en)                      w_state_nxt = ST_IDLE;
                else if (w_accept && w_valid) w_state_nxt = ST_SW_PEND;
            end
            ST_SW_PEND: begin
                if (!en)         w_state_nxt = ST_IDLE;
                else if (w_wrap) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Next values of counter, ratio and handshake; clk_o/tick derive from the
    // post-edge counter and ratio so they line up with cnt in the same cycle.
    always_comb begin
        w_cnt_nxt  = '0;
        w_div_nxt  = r_div_cur;
        w_pend_nxt = r_pend;
        w_ack_nxt  = 1'b0;
        w_err_nxt  = w_accept && !w_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_valid) begin
                    w_div_nxt  = div_val;
                    w_pend_nxt = div_val;
                    w_ack_nxt  = 1'b1;
                end
            end
            ST_RUN: begin
                if (en) begin
                    w_cnt_nxt = w_wrap ? '0 : r_cnt + CNT_W'(1);
                    if (w_accept && w_valid) w_pend_nxt = div_val;
                end else if (w_accept && w_valid) begin
                    // Leaving to idle: nothing to wait for, apply at once.
                    w_div_nxt  = div_val;
                    w_pend_nxt = div_val;
                    w_ack_nxt  = 1'b1;
                end
            end
            ST_SW_PEND: begin
                if (!en || w_wrap) begin
                    w_div_nxt = r_pend;
                    w_ack_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
        w_run_nxt   = (w_state_nxt != ST_IDLE);
        w_hi_len    = w_div_nxt >> 1;
        w_clk_o_nxt = w_run_nxt && (w_cnt_nxt < w_hi_len);
        w_tick_nxt  = w_run_nxt && (w_cnt_nxt == (w_div_nxt - CNT_W'(1)));
        w_busy_nxt  = (w_state_nxt == ST_SW_PEND);
    end

    assign div_ack = r_div_ack;
    assign div_err = r_div_err;
    assign div_cur = r_div_cur;
    assign clk_o   = r_clk_o;
    assign tick    = r_tick;
    assign busy    = r_busy;

endmodule
